// File: rtl/pipe_flow_ctrl_pkg.sv
// rtl/pipe_flow_ctrl_pkg.sv - shared types and constants for the pipeline flow controller
package pipe_flow_ctrl_pkg;

    localparam int DRAIN_CYCLES_DEF = 3;
    localparam int PERF_W_DEF       = 16;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_RUN,
        ST_MEMWAIT,
        ST_DRAIN,
        ST_HALTED
    } pipe_ctrl_state_e;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_write;
        logic id_ex_flush;
        logic ex_mem_write;
        logic mem_wb_write;
    } pipe_ctrl_t;

    // Flush bits override the matching write bit inside the pipe registers.
    localparam pipe_ctrl_t CTRL_FREEZE = pipe_ctrl_t'(7'b000_0000);
    localparam pipe_ctrl_t CTRL_CLEAR  = pipe_ctrl_t'(7'b001_0100);
    localparam pipe_ctrl_t CTRL_RUN    = pipe_ctrl_t'(7'b110_1011);
    localparam pipe_ctrl_t CTRL_BRANCH = pipe_ctrl_t'(7'b111_1111);
    localparam pipe_ctrl_t CTRL_BUBBLE = pipe_ctrl_t'(7'b000_1111);
    localparam pipe_ctrl_t CTRL_DRAIN  = pipe_ctrl_t'(7'b011_1111);

endpackage

// File: rtl/pipe_flow_ctrl_hazard.sv
// rtl/pipe_flow_ctrl_hazard.sv - load-use hazard compare between ID/EX load and IF/ID sources
module pipe_hazard_detect (
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       ex_memread,
    input  logic [4:0] ex_rd,
    output logic       load_use_stall
);

    // x0 is never a real dependency, so a load targeting it cannot stall.
    assign load_use_stall = ex_memread && (ex_rd != 5'd0) &&
                            ((ex_rd == id_rs1) || (ex_rd == id_rs2));

endmodule

// File: rtl/pipe_flow_ctrl.sv
// rtl/pipe_flow_ctrl.sv - pipeline register enable/flush sequencer with stall, flush and halt drain
module pipe_flow_ctrl
    import pipe_flow_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
    parameter int PERF_W       = PERF_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic              ex_memread,
    input  logic [4:0]        ex_rd,
    input  logic              ex_halt,
    input  logic              ex_pc_sel,
    input  logic              mem_access,
    input  logic              dmem_ready,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              if_id_flush,
    output logic              id_ex_write,
    output logic              id_ex_flush,
    output logic              ex_mem_write,
    output logic              mem_wb_write,
    output logic              halted,
    output logic [PERF_W-1:0] stall_cnt,
    output logic [PERF_W-1:0] flush_cnt
);

    localparam int                 DCNT_W     = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DCNT_W-1:0]  DRAIN_LOAD = DCNT_W'(DRAIN_CYCLES - 1);
    localparam logic [PERF_W-1:0]  PERF_MAX   = '1;

    pipe_ctrl_state_e  state_q, state_d;
    logic              ret_drain_q, ret_drain_d;
    logic [DCNT_W-1:0] drain_cnt_q, drain_cnt_d;
    logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [PERF_W-1:0] flush_cnt_q, flush_cnt_d;

    pipe_ctrl_t ctrl;
    logic       load_use_stall;
    logic       mem_wait;
    logic       stall_inc;
    logic       flush_inc;

    pipe_hazard_detect u_hazard (
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .ex_memread     (ex_memread),
        .ex_rd          (ex_rd),
        .load_use_stall (load_use_stall)
    );

    assign mem_wait = mem_access && !dmem_ready;

    always_comb begin
        state_d     = state_q;
        ret_drain_d = ret_drain_q;
        drain_cnt_d = drain_cnt_q;
        ctrl        = CTRL_RUN;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        halted      = 1'b0;
        case (state_q)
            ST_INIT: begin
                ctrl    = CTRL_CLEAR;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (mem_wait) begin
                    ctrl        = CTRL_FREEZE;
                    stall_inc   = 1'b1;
                    ret_drain_d = 1'b0;
                    state_d     = ST_MEMWAIT;
                end else if (ex_halt) begin
                    ctrl        = CTRL_DRAIN;
                    drain_cnt_d = DRAIN_LOAD;
                    state_d     = ST_DRAIN;
                end else if (ex_pc_sel) begin
                    ctrl      = CTRL_BRANCH;
                    flush_inc = 1'b1;
                end else if (load_use_stall) begin
                    ctrl      = CTRL_BUBBLE;
                    stall_inc = 1'b1;
                end
            end
            ST_MEMWAIT: begin
                if (!dmem_ready) begin
                    ctrl      = CTRL_FREEZE;
                    stall_inc = 1'b1;
                end else begin
                    state_d = ret_drain_q ? ST_DRAIN : ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (mem_wait) begin
                    ctrl        = CTRL_FREEZE;
                    stall_inc   = 1'b1;
                    ret_drain_d = 1'b1;
                    state_d     = ST_MEMWAIT;
                end else begin
                    ctrl = CTRL_DRAIN;
                    if (drain_cnt_q == '0) begin
                        state_d = ST_HALTED;
                    end else begin
                        drain_cnt_d = drain_cnt_q - DCNT_W'(1);
                    end
                end
            end
            ST_HALTED: begin
                ctrl   = CTRL_FREEZE;
                halted = 1'b1;
            end
            default: begin
                ctrl    = CTRL_CLEAR;
                state_d = ST_INIT;
            end
        endcase

        stall_cnt_d = (stall_inc && stall_cnt_q != PERF_MAX) ? stall_cnt_q + PERF_W'(1) : stall_cnt_q;
        flush_cnt_d = (flush_inc && flush_cnt_q != PERF_MAX) ? flush_cnt_q + PERF_W'(1) : flush_cnt_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_INIT;
            ret_drain_q <= 1'b0;
            drain_cnt_q <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ret_drain_q <= ret_drain_d;
            drain_cnt_q <= drain_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign {pc_write, if_id_write, if_id_flush, id_ex_write,
            id_ex_flush, ex_mem_write, mem_wb_write} = ctrl;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// tb/tb_pipe_flow_ctrl.sv - randomized self-checking bench for pipe_flow_ctrl
module tb_pipe_flow_ctrl;

    logic        clk;
    logic        reset;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        ex_memread, ex_halt, ex_pc_sel, mem_access, dmem_ready;
    logic        pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush;
    logic        ex_mem_write, mem_wb_write, halted;
    logic [15:0] stall_cnt, flush_cnt;

    int n_compared;
    int n_mismatched;

    // Reference model: pipeline situation flags plus plain integer counters.
    bit m_init, m_wait, m_drain, m_halted;
    int m_left, m_stalls, m_flushes;

    pipe_flow_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .ex_memread   (ex_memread),
        .ex_rd        (ex_rd),
        .ex_halt      (ex_halt),
        .ex_pc_sel    (ex_pc_sel),
        .mem_access   (mem_access),
        .dmem_ready   (dmem_ready),
        .pc_write     (pc_write),
        .if_id_write  (if_id_write),
        .if_id_flush  (if_id_flush),
        .id_ex_write  (id_ex_write),
        .id_ex_flush  (id_ex_flush),
        .ex_mem_write (ex_mem_write),
        .mem_wb_write (mem_wb_write),
        .halted       (halted),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] ctrl_vec();
        return {pc_write, if_id_write, if_id_flush, id_ex_write,
                id_ex_flush, ex_mem_write, mem_wb_write};
    endfunction

    task automatic model_reset();
        m_init    = 1'b1;
        m_wait    = 1'b0;
        m_drain   = 1'b0;
        m_halted  = 1'b0;
        m_left    = 0;
        m_stalls  = 0;
        m_flushes = 0;
    endtask

    // Asserts reset mid-cycle, checks the held-in-reset outputs, releases after two edges.
    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        #1;
        check_eq("rst_ctrl", 32'(ctrl_vec()), 32'h14);
        check_eq("rst_halted", 32'(halted), 32'd0);
        check_eq("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        check_eq("rst_flush_cnt", 32'(flush_cnt), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Called at posedge+1: drive, check at mid-cycle, then advance model over the edge.
    task automatic run_cycle(input logic [4:0] rs1, input logic [4:0] rs2, input logic memread,
                             input logic [4:0] rd, input logic halt, input logic pc_sel,
                             input logic macc, input logic rdy);
        logic [6:0] exp;
        bit hz, mw, n_init, n_wait, n_drain, n_halted, st_inc, fl_inc;
        int n_left;
        id_rs1 = rs1; id_rs2 = rs2; ex_memread = memread; ex_rd = rd;
        ex_halt = halt; ex_pc_sel = pc_sel; mem_access = macc; dmem_ready = rdy;
        #4;
        hz = memread && rd != 5'd0 && (rd == rs1 || rd == rs2);
        mw = macc && !rdy;
        exp = 7'b1101011;
        n_init = m_init; n_wait = m_wait; n_drain = m_drain; n_halted = m_halted; n_left = m_left;
        st_inc = 1'b0; fl_inc = 1'b0;
        if (m_init) begin
            exp = 7'b0010100;
            n_init = 1'b0;
        end else if (m_halted) begin
            exp = 7'b0000000;
        end else if (m_wait) begin
            if (!rdy) begin
                exp = 7'b0000000;
                st_inc = 1'b1;
            end else begin
                n_wait = 1'b0;
            end
        end else if (m_drain) begin
            if (mw) begin
                exp = 7'b0000000; st_inc = 1'b1; n_wait = 1'b1;
            end else begin
                exp = 7'b0111111;
                if (m_left == 0) begin
                    n_drain = 1'b0; n_halted = 1'b1;
                end else begin
                    n_left = m_left - 1;
                end
            end
        end else begin
            if (mw) begin
                exp = 7'b0000000; st_inc = 1'b1; n_wait = 1'b1;
            end else if (halt) begin
                exp = 7'b0111111; n_drain = 1'b1; n_left = 2;
            end else if (pc_sel) begin
                exp = 7'b1111111; fl_inc = 1'b1;
            end else if (hz) begin
                exp = 7'b0001111; st_inc = 1'b1;
            end
        end
        check_eq("ctrl", 32'(ctrl_vec()), 32'(exp));
        check_eq("halted", 32'(halted), 32'(m_halted));
        check_eq("stall_cnt", 32'(stall_cnt), 32'(m_stalls));
        check_eq("flush_cnt", 32'(flush_cnt), 32'(m_flushes));
        @(posedge clk);
        m_init = n_init; m_wait = n_wait; m_drain = n_drain; m_halted = n_halted; m_left = n_left;
        if (st_inc && m_stalls < 65535) m_stalls++;
        if (fl_inc && m_flushes < 65535) m_flushes++;
        #1;
    endtask

    task automatic idle_cycle();
        run_cycle(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        n_compared = 0;
        n_mismatched = 0;
        reset = 1'b1;
        {id_rs1, id_rs2, ex_rd} = '0;
        {ex_memread, ex_halt, ex_pc_sel, mem_access} = '0;
        dmem_ready = 1'b1;
        @(posedge clk);
        #1;
        do_reset();

        // INIT then plain RUN, then a single load-use bubble
        idle_cycle();
        idle_cycle();
        run_cycle(5'd5, 5'd9, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("lu_stall_cnt", 32'(stall_cnt), 32'd1);
        run_cycle(5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        run_cycle(5'd5, 5'd5, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0, 1'b1);
        check_eq("br_flush_cnt", 32'(flush_cnt), 32'd1);
        check_eq("br_stall_cnt", 32'(stall_cnt), 32'd1);

        // Four-cycle memory wait from RUN
        do_reset();
        idle_cycle();
        for (int i = 0; i < 4; i++) run_cycle(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("mw_stall_cnt", 32'(stall_cnt), 32'd4);
        run_cycle(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        idle_cycle();

        // Halt with a two-cycle memory wait inside the drain
        do_reset();
        idle_cycle();
        run_cycle(5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1);
        idle_cycle();
        run_cycle(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        run_cycle(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        run_cycle(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        idle_cycle();
        idle_cycle();
        check_eq("drain_halted", 32'(halted), 32'd1);
        check_eq("drain_flush_cnt", 32'(flush_cnt), 32'd0);
        idle_cycle();

        // Randomized traffic, re-reset whenever the pipeline has halted
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (m_halted && $urandom_range(0, 3) == 0) do_reset();
            run_cycle(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      5'($urandom_range(0, 3)), 1'($urandom_range(0, 39) == 0),
                      1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 2) == 0),
                      1'($urandom_range(0, 2) != 0));
        end

        // Flush counter saturation, then reset in the middle of a drain
        do_reset();
        idle_cycle();
        for (int i = 0; i < 65541; i++) run_cycle(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        check_eq("sat_flush_cnt", 32'(flush_cnt), 32'hFFFF);
        run_cycle(5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        idle_cycle();
        do_reset();
        check_eq("mid_drain_halted", 32'(halted), 32'd0);
        idle_cycle();
        idle_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
